uart_tx_gen: RTL and testbench
==============================

UART_TX_GEN -- requirements
Module: uart_tx_gen

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, data bits per frame, legal range 5..9.
REQ-002 SHALL provide parameter PRESCALE_W, default 16, width of the baud prescale input.
REQ-003 SHALL provide parameter FIFO_DEPTH, default 4, transmit FIFO entries, power of two, 2..16.
REQ-004 clk  input  1  sole clock; all logic updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 p_data  input  DATA_W  parallel word to transmit.
REQ-007 data_valid  input  1  p_data is offered this cycle.
REQ-008 data_ready  output  1  FIFO can accept a word; equals not-full.
REQ-009 par_en  input  1  1 inserts a parity bit after the data bits.
REQ-010 par_typ  input  1  parity type: 0 even, 1 odd.
REQ-011 stop2  input  1  0 gives one stop bit, 1 gives two.
REQ-012 prescale  input  PRESCALE_W  bit period minus one, in clk cycles.
REQ-013 busy  output  1  high while any frame bit is driven on out_tx.
REQ-014 fifo_cnt  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-015 out_tx  output  1  registered serial line; idle level high.

Function
REQ-016 SHALL write p_data into the FIFO on any rising edge where data_valid and data_ready are both 1; data_valid while data_ready is 0 SHALL be ignored.
REQ-017 If a push and a pop occur in the same cycle, both SHALL take effect and fifo_cnt SHALL be unchanged.
REQ-018 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-019 In IDLE with fifo_cnt>0, the FSM SHALL pop one word, latch it together with par_en, par_typ, stop2 and prescale, and enter START on the next edge.
REQ-020 Changes to the configuration inputs during a frame SHALL NOT affect that frame.
REQ-021 Each frame bit SHALL last exactly prescale+1 clk cycles, so prescale=0 gives 1 cycle per bit.
REQ-022 START SHALL drive out_tx=0 for one bit period, then go to DATA.
REQ-023 DATA SHALL drive DATA_W bits, LSB first, one bit period each.
REQ-024 After DATA, the FSM SHALL go to PARITY if the latched par_en is 1, otherwise to STOP.
REQ-025 PARITY SHALL drive, for one bit period, the XOR of the data bits when par_typ=0, and its inverse when par_typ=1; then go to STOP.
REQ-026 STOP SHALL drive out_tx=1 for 1 bit period, or 2 when the latched stop2 is 1.
REQ-027 At the last cycle of STOP with fifo_cnt>0, the FSM SHALL pop the next word and enter START directly, with no idle cycle between frames.
REQ-028 At the last cycle of STOP with an empty FIFO, the FSM SHALL return to IDLE.
REQ-029 Latency, from idle with the FIFO empty: a word accepted at edge N SHALL have out_tx=0 from edge N+2.
REQ-030 busy SHALL be a registered output that is 1 exactly during the cycles in which out_tx carries START through the final STOP bit.
REQ-031 Frame length SHALL be (1+DATA_W+par_en+1+stop2)*(prescale+1) cycles.

Reset
REQ-032 While rst=1 at a rising edge, the block SHALL set out_tx=1, busy=0, fifo_cnt=0, data_ready=1, and the FSM to IDLE.
REQ-033 rst asserted mid-frame SHALL abort the frame and discard the FIFO contents; out_tx SHALL be 1 on the edge following that reset edge.

Verification
REQ-034 Case 1, DATA_W=8, prescale=0, par_en=0, stop2=0, push 0xA5: out_tx SHALL read 0,1,0,1,0,0,1,0,1,1, then stay idle high; busy SHALL be high for 10 cycles.
REQ-035 Case 2, same as case 1 with par_en=1: par_typ=0 SHALL give parity bit 0 and par_typ=1 SHALL give parity bit 1; frame length SHALL be 11 cycles.
REQ-036 Case 3, prescale=3, stop2=1, par_en=1, push 0x00: frame SHALL be 48 cycles, and every bit SHALL be held for 4 cycles.
REQ-037 Case 4, FIFO_DEPTH=4, push 0x01, 0x02, 0x03, 0x04, 0x05 back-to-back: data_ready SHALL drop when the FIFO is full, and the word is accepted only after a pop; all five frames SHALL go out in order with no idle gap, and busy SHALL stay continuously high.
REQ-038 Case 5, assert rst for one cycle at the 5th data bit of a frame with 2 words queued: out_tx=1, busy=0 and fifo_cnt=0 SHALL hold afterwards, and no further frames SHALL be sent.
REQ-039 Case 6, change par_en, stop2 and prescale mid-frame: the current frame SHALL be unaffected, and the next frame SHALL use the new values.

Source files
------------

// File: rtl/uart_tx_gen.sv
// ============================================================================
// Module      : uart_tx_gen
// Description : FIFO-buffered UART transmitter with per-frame parity/stop/baud
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_gen #(
    parameter int DATA_W     = 8,
    parameter int PRESCALE_W = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             p_data,
    input  logic                          data_valid,
    output logic                          data_ready,
    input  logic                          par_en,
    input  logic                          par_typ,
    input  logic                          stop2,
    input  logic [PRESCALE_W-1:0]         prescale,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
    output logic                          out_tx
);

    localparam int                c_addr_w   = $clog2(FIFO_DEPTH);
    localparam logic [c_addr_w:0] c_full     = (c_addr_w + 1)'(FIFO_DEPTH);
    localparam logic [3:0]        c_last_bit = 4'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic [DATA_W-1:0]     r_mem [FIFO_DEPTH];
    logic [c_addr_w-1:0]   r_wr_ptr;
    logic [c_addr_w-1:0]   r_rd_ptr;
    logic [c_addr_w:0]     r_count;
    logic                  w_push;
    logic                  w_pop;

    logic [DATA_W-1:0]     r_shift;
    logic                  r_parity;
    logic                  r_par_en_l;
    logic                  r_stop2_l;
    logic [PRESCALE_W-1:0] r_prescale_l;
    logic [PRESCALE_W-1:0] r_baud;
    logic [3:0]            r_bit_cnt;
    logic                  w_bit_end;
    logic                  w_tx_bit;
    logic                  w_busy;
    logic                  r_tx;
    logic                  r_busy;

    assign data_ready = (r_count != c_full);
    assign w_push     = data_valid && data_ready;
    assign fifo_cnt   = r_count;
    assign busy       = r_busy;
    assign out_tx     = r_tx;
    assign w_bit_end  = (r_baud == r_prescale_l);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= p_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_pop    = 1'b0;
        w_tx_bit = 1'b1;
        w_busy   = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (r_count != '0) begin
                    w_pop  = 1'b1;
                    w_next = S_START;
                end
            end
            S_START: begin
                w_tx_bit = 1'b0;
                if (w_bit_end) begin
                    w_next = S_DATA;
                end
            end
            S_DATA: begin
                w_tx_bit = r_shift[0];
                if (w_bit_end && (r_bit_cnt == c_last_bit)) begin
                    w_next = r_par_en_l ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                w_tx_bit = r_parity;
                if (w_bit_end) begin
                    w_next = S_STOP;
                end
            end
            S_STOP: begin
                // Chain straight into the next start bit when more words wait.
                if (w_bit_end && (r_bit_cnt == {3'b000, r_stop2_l})) begin
                    if (r_count != '0) begin
                        w_pop  = 1'b1;
                        w_next = S_START;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_busy = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    // out_tx/busy are the FSM outputs delayed one clock, keeping them glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_shift      <= '0;
            r_parity     <= 1'b0;
            r_par_en_l   <= 1'b0;
            r_stop2_l    <= 1'b0;
            r_prescale_l <= '0;
            r_baud       <= '0;
            r_bit_cnt    <= '0;
        end else begin
            r_tx   <= w_tx_bit;
            r_busy <= w_busy;
            if (w_pop) begin
                r_shift      <= r_mem[r_rd_ptr];
                r_parity     <= (^r_mem[r_rd_ptr]) ^ par_typ;
                r_par_en_l   <= par_en;
                r_stop2_l    <= stop2;
                r_prescale_l <= prescale;
                r_baud       <= '0;
                r_bit_cnt    <= '0;
            end else if (r_state != S_IDLE) begin
                if (w_bit_end) begin
                    r_baud <= '0;
                    if (w_next != r_state) begin
                        r_bit_cnt <= '0;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                    if (r_state == S_DATA) begin
                        r_shift <= r_shift >> 1;
                    end
                end else begin
                    r_baud <= r_baud + 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_gen.sv
// ============================================================================
// Module      : tb_uart_tx_gen
// Description : Scoreboard bench for uart_tx_gen: queued expected frames vs line
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_gen;

    typedef struct {
        logic [15:0] bits;
        int          len;
        int          period;
    } frame_t;

    logic        clk;
    logic        rst;
    logic [7:0]  p_data;
    logic        data_valid;
    logic        data_ready;
    logic        par_en;
    logic        par_typ;
    logic        stop2;
    logic [15:0] prescale;
    logic        busy;
    logic [2:0]  fifo_cnt;
    logic        out_tx;

    int     total;
    int     bad;
    logic   flush;
    frame_t exp_q[$];

    uart_tx_gen #(
        .DATA_W    (8),
        .PRESCALE_W(16),
        .FIFO_DEPTH(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .p_data    (p_data),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .par_en    (par_en),
        .par_typ   (par_typ),
        .stop2     (stop2),
        .prescale  (prescale),
        .busy      (busy),
        .fifo_cnt  (fifo_cnt),
        .out_tx    (out_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic frame_t make_frame(input logic [7:0] d, input logic pe, input logic pt,
                                          input logic s2, input logic [15:0] ps);
        frame_t f;
        int     k;
        f.bits = '0;
        k = 0;
        f.bits[k] = 1'b0;
        k = k + 1;
        for (int i = 0; i < 8; i++) begin
            f.bits[k] = d[i];
            k = k + 1;
        end
        if (pe) begin
            f.bits[k] = (^d) ^ pt;
            k = k + 1;
        end
        f.bits[k] = 1'b1;
        k = k + 1;
        if (s2) begin
            f.bits[k] = 1'b1;
            k = k + 1;
        end
        f.len    = k;
        f.period = int'(ps) + 1;
        return f;
    endfunction

    task automatic push_exp(input logic [7:0] d, input frame_t f);
        int n;
        @(negedge clk);
        p_data     = d;
        data_valid = 1'b1;
        n = 0;
        while (!data_ready && n < 200) begin
            @(negedge clk);
            n = n + 1;
        end
        check("push accept timeout", 32'(n < 200), 32'd1);
        @(posedge clk);
        exp_q.push_back(f);
        #1;
        data_valid = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        push_exp(d, make_frame(d, par_en, par_typ, stop2, prescale));
    endtask

    task automatic busy_len(output int n);
        int t;
        t = 0;
        while (!busy && t < 100) begin
            @(posedge clk);
            #1;
            t = t + 1;
        end
        n = 0;
        while (busy && n < 200) begin
            n = n + 1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 2000) begin
            @(negedge clk);
            n = n + 1;
        end
        check("drain timeout", 32'(n < 2000), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    // Monitor: every frame on the line must match the head of the expected queue.
    initial begin
        frame_t e;
        bit     have_start;
        bit     aborted;
        have_start = 1'b0;
        forever begin
            if (!have_start) begin
                @(negedge clk);
                if (flush || rst || out_tx !== 1'b0) continue;
            end
            have_start = 1'b0;
            if (exp_q.size() == 0) begin
                check("unexpected frame start", 32'(out_tx), 32'd1);
                continue;
            end
            e = exp_q.pop_front();
            aborted = 1'b0;
            for (int i = 0; i < e.len && !aborted; i++) begin
                for (int c = 0; c < e.period; c++) begin
                    if (i != 0 || c != 0) begin
                        @(negedge clk);
                        if (flush) begin
                            aborted = 1'b1;
                            break;
                        end
                    end
                    check("frame bit {busy,tx}", 32'({busy, out_tx}), 32'({1'b1, e.bits[i]}));
                end
            end
            if (aborted) continue;
            @(negedge clk);
            if (flush) continue;
            if (exp_q.size() > 0) begin
                check("no gap between frames", 32'(out_tx), 32'd0);
                have_start = (out_tx === 1'b0);
            end else begin
                check("idle after frame {busy,tx}", 32'({busy, out_tx}), 32'b01);
            end
        end
    end

    initial begin
        int n;
        int errs;
        total      = 0;
        bad        = 0;
        flush      = 1'b0;
        rst        = 1'b1;
        data_valid = 1'b0;
        p_data     = '0;
        par_en     = 1'b0;
        par_typ    = 1'b0;
        stop2      = 1'b0;
        prescale   = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset out_tx", 32'(out_tx), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset fifo_cnt", 32'(fifo_cnt), 32'd0);
        check("reset data_ready", 32'(data_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Case 1: 0xA5, 8N1, one cycle per bit
        push_exp(8'hA5, '{bits: 16'({1'b1, 8'hA5, 1'b0}), len: 10, period: 1});
        @(posedge clk);
        #1;
        check("latency edge N+1 out_tx", 32'(out_tx), 32'd1);
        @(posedge clk);
        #1;
        check("latency edge N+2 out_tx", 32'(out_tx), 32'd0);
        n = 0;
        while (busy && n < 200) begin
            n = n + 1;
            @(posedge clk);
            #1;
        end
        check("case1 busy cycles", n, 32'd10);
        wait_idle();

        // Case 2: even then odd parity on 0xA5 (four ones)
        par_en  = 1'b1;
        par_typ = 1'b0;
        push_exp(8'hA5, '{bits: 16'({1'b1, 1'b0, 8'hA5, 1'b0}), len: 11, period: 1});
        busy_len(n);
        check("case2 even busy cycles", n, 32'd11);
        wait_idle();
        par_typ = 1'b1;
        push_exp(8'hA5, '{bits: 16'({1'b1, 1'b1, 8'hA5, 1'b0}), len: 11, period: 1});
        busy_len(n);
        check("case2 odd busy cycles", n, 32'd11);
        wait_idle();

        // Case 3: 0x00, even parity, two stops, four cycles per bit
        par_typ  = 1'b0;
        stop2    = 1'b1;
        prescale = 16'd3;
        push_exp(8'h00, '{bits: 16'({2'b11, 1'b0, 8'h00, 1'b0}), len: 12, period: 4});
        busy_len(n);
        check("case3 busy cycles", n, 32'd48);
        wait_idle();

        // Case 4: five words back-to-back into a 4-deep FIFO, then one more
        par_en   = 1'b0;
        stop2    = 1'b0;
        prescale = 16'd0;
        push(8'h01);
        check("case4 cnt after push1", 32'(fifo_cnt), 32'd1);
        push(8'h02);
        check("case4 cnt push+pop", 32'(fifo_cnt), 32'd1);
        push(8'h03);
        check("case4 cnt after push3", 32'(fifo_cnt), 32'd2);
        push(8'h04);
        check("case4 cnt after push4", 32'(fifo_cnt), 32'd3);
        push(8'h05);
        check("case4 cnt full", 32'(fifo_cnt), 32'd4);
        check("case4 data_ready when full", 32'(data_ready), 32'd0);
        push(8'h06);
        check("case4 cnt after late push", 32'(fifo_cnt), 32'd4);
        errs = 0;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            if (!busy) errs = errs + 1;
            n = n + 1;
        end
        check("case4 busy low cycles", errs, 32'd0);
        wait_idle();

        // Case 5: reset during data bit 4 of 0x11 with two words queued
        push(8'h11);
        push(8'h22);
        push(8'h33);
        @(negedge clk);
        repeat (5) @(negedge clk);
        check("case5 at data bit 4 {busy,tx}", 32'({busy, out_tx}), 32'b11);
        check("case5 queued before reset", 32'(fifo_cnt), 32'd2);
        flush = 1'b1;
        rst   = 1'b1;
        @(posedge clk);
        #1;
        check("case5 reset out_tx", 32'(out_tx), 32'd1);
        check("case5 reset busy", 32'(busy), 32'd0);
        check("case5 reset fifo_cnt", 32'(fifo_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        errs = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_tx !== 1'b1 || busy !== 1'b0 || fifo_cnt !== 3'd0) errs = errs + 1;
        end
        check("case5 quiet after reset", errs, 32'd0);
        flush = 1'b0;

        // Case 6: configuration changed while a frame is on the line
        prescale = 16'd1;
        push(8'h3C);
        n = 0;
        while (!busy && n < 100) begin
            @(negedge clk);
            n = n + 1;
        end
        check("case6 frame started", 32'(busy), 32'd1);
        par_en   = 1'b1;
        par_typ  = 1'b1;
        stop2    = 1'b1;
        prescale = 16'd2;
        push(8'hC3);
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n = n + 1;
        end
        check("case6 remaining busy ends", 32'(busy), 32'd0);
        wait_idle();

        check("leftover expected frames", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
